fp_mult_scheduler: RTL and testbench

Round-robin scheduler that time-shares one fixed-point multiplier (operand width WORD_LENGTH, product width 2*WORD_LENGTH) among N_REQ synthesizer requesters, such as the oscillator×envelope and mixer gain stages. It accepts operand pairs over valid/ready handshakes and drives the registered operands to the external multiplier. It then captures the product, reduces it to WORD_LENGTH, and returns it with the requester ID over a valid/ready response channel.

---
 rtl/fp_mult_scheduler.sv | 158 +++++++++++++++
 tb/tb_fp_mult_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_scheduler.sv
// Round-robin scheduler sharing one fixed-point multiplier among N_REQ requesters.
// Optional macro FP_MULT_SCHED_ROUND_EN selects round-half-up with saturation instead of truncation.
module fp_mult_scheduler #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned N_REQ       = 4,
    localparam int unsigned ID_W       = $clog2(N_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*WORD_LENGTH-1:0]   req_a,
    input  logic [N_REQ*WORD_LENGTH-1:0]   req_b,
    output logic [WORD_LENGTH-1:0]         mul_a,
    output logic [WORD_LENGTH-1:0]         mul_b,
    input  logic [2*WORD_LENGTH-1:0]       mul_p,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [WORD_LENGTH-1:0]         rsp_data,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           busy
);

    localparam int unsigned W = WORD_LENGTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    mul_a_q, mul_a_d;
    logic [W-1:0]    mul_b_q, mul_b_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] rr_last_q, rr_last_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;

    logic            accept_c;
    logic            found_c;
    logic [ID_W-1:0] grant_c;
    logic            take_c;
    logic [W-1:0]    reduced_c;

    // Product reduction to W bits
    always_comb begin
`ifdef FP_MULT_SCHED_ROUND_EN
        logic [W-1:0] top;
        top = mul_p[2*W-1:W];
        if (mul_p[W-1] && (top == {1'b0, {(W-1){1'b1}}})) begin
            reduced_c = top;
        end else begin
            reduced_c = top + W'(mul_p[W-1]);
        end
`else
        reduced_c = mul_p[2*W-1:W];
`endif
    end

    // Round-robin search starting just after the last grant
    always_comb begin
        int unsigned j;
        found_c = 1'b0;
        grant_c = '0;
        j       = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            j = (32'(rr_last_q) + k) % N_REQ;
            if (!found_c && req_valid[ID_W'(j)]) begin
                found_c = 1'b1;
                grant_c = ID_W'(j);
            end
        end
    end

    assign accept_c = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign take_c   = accept_c && found_c;

    always_comb begin
        req_ready = '0;
        if (take_c) begin
            req_ready[grant_c] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        id_d        = id_q;
        rr_last_d   = rr_last_q;
        rsp_valid_d = rsp_valid_q;

        if (take_c) begin
            mul_a_d   = req_a[32'(grant_c)*W +: W];
            mul_b_d   = req_b[32'(grant_c)*W +: W];
            id_d      = grant_c;
            rr_last_d = grant_c;
        end

        case (state_q)
            IDLE: begin
                if (take_c) state_d = MUL;
            end
            MUL: begin
                rsp_data_d  = reduced_c;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = take_c ? MUL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            id_q        <= '0;
            rr_last_q   <= ID_W'(N_REQ - 1);
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            id_q        <= id_d;
            rr_last_q   <= rr_last_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp_mult_scheduler.sv
// Directed self-checking bench for fp_mult_scheduler (W=8, N_REQ=4).
module tb_fp_mult_scheduler;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_p;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [1:0]       rsp_id;
    logic             busy;

    logic             ovr_en;
    logic [2*W-1:0]   ovr_p;

    int total;
    int bad;

    fp_mult_scheduler #(.WORD_LENGTH(W), .N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    // Multiplier model: real signed product unless a test forces a value
    assign mul_p = ovr_en ? ovr_p : 16'($signed(mul_a) * $signed(mul_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; ovr_en = 1'b0; ovr_p = '0;
        req_a = '0; req_b = '0;
        #7;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if ({mul_a, mul_b} !== 16'h0) begin bad++; $display("FAIL reset_mul got=%h want=0000", {mul_a, mul_b}); end
        total++; if ({rsp_data, rsp_id} !== 10'h0) begin bad++; $display("FAIL reset_rsp got=%h want=000", {rsp_data, rsp_id}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [W-1:0] exp_d;
`ifdef FP_MULT_SCHED_ROUND_EN
        exp_d = 8'h13;
`else
        exp_d = 8'h12;
`endif
        ovr_en = 1'b1; ovr_p = 16'h12C0;
        req_a[2*W +: W] = 8'h11; req_b[2*W +: W] = 8'h22;
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
        tick();
        req_valid = '0;
        total++; if ({mul_a, mul_b} !== 16'h1122) begin bad++; $display("FAIL single_ops got=%h want=1122", {mul_a, mul_b}); end
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_mul_phase got=%b%b want=01", rsp_valid, busy); end
        tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", rsp_valid); end
        total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d want=2", rsp_id); end
        total++; if (rsp_data !== exp_d) begin bad++; $display("FAIL single_data got=%h want=%h", rsp_data, exp_d); end
        rsp_ready = 1'b1;
        tick();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b%b want=00", rsp_valid, busy); end
        rsp_ready = 1'b0; ovr_en = 1'b0;
    endtask

    task automatic test_reset_mid_resp();
        req_a[3*W +: W] = 8'h05; req_b[3*W +: W] = 8'h07;
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b want=1", rsp_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", rsp_valid); end
        total++; if ({mul_a, mul_b} !== 16'h0) begin bad++; $display("FAIL midrst_mul got=%h want=0000", {mul_a, mul_b}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        #3;
        rst_n = 1'b1;
        tick();
        req_valid = 4'b1111;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_first got=%b want=0001", req_ready); end
        req_valid = '0;
        tick();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp got=%b%b want=00", rsp_valid, busy); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_r;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 8'((i + 1) * 16);
            req_b[i*W +: W] = 8'h10;
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_r = 4'b0001 << (k % 4);
            #1;
            total++; if (req_ready !== exp_r) begin bad++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, req_ready, exp_r); end
            tick();
            total++; if (mul_a !== 8'((k % 4 + 1) * 16) || rsp_valid !== 1'b0) begin bad++; $display("FAIL rr_mul[%0d] got=%h/%b want=%h/0", k, mul_a, rsp_valid, 8'((k % 4 + 1) * 16)); end
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_mul_ready[%0d] got=%b want=0000", k, req_ready); end
            tick();
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_data !== 8'(k % 4 + 1)) begin
                bad++; $display("FAIL rr_rsp[%0d] got=%b/%0d/%h want=1/%0d/%h", k, rsp_valid, rsp_id, rsp_data, k % 4, 8'(k % 4 + 1));
            end
        end
        req_valid = '0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_end_busy got=%b want=0", busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b want=0010", req_ready); end
        tick();
        req_valid = 4'b0101;
        tick();
        for (int c = 0; c < 5; c++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h02 || busy !== 1'b1 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h/%b/%b want=1/1/02/1/0000", c, rsp_valid, rsp_id, rsp_data, busy, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_release got=%b want=0100", req_ready); end
        tick();
        req_valid = '0;
        total++; if (rsp_valid !== 1'b0 || mul_a !== 8'h30 || busy !== 1'b1) begin bad++; $display("FAIL bp_next got=%b/%h/%b want=0/30/1", rsp_valid, mul_a, busy); end
        tick();
        total++; if (rsp_id !== 2'd2 || rsp_data !== 8'h03) begin bad++; $display("FAIL bp_next_rsp got=%0d/%h want=2/03", rsp_id, rsp_data); end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_saturation();
        logic [W-1:0] exp_hi, exp_neg;
`ifdef FP_MULT_SCHED_ROUND_EN
        exp_hi = 8'h7F; exp_neg = 8'h00;
`else
        exp_hi = 8'h7F; exp_neg = 8'hFF;
`endif
        ovr_en = 1'b1; rsp_ready = 1'b1;
        ovr_p = 16'h7FFF;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        total++; if (rsp_data !== exp_hi) begin bad++; $display("FAIL sat_pos got=%h want=%h", rsp_data, exp_hi); end
        tick();
        ovr_p = 16'hFF80;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        total++; if (rsp_data !== exp_neg) begin bad++; $display("FAIL sat_neg got=%h want=%h", rsp_data, exp_neg); end
        tick();
        ovr_en = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_withdrawn();
        req_a[0 +: W] = 8'h09; req_b[0 +: W] = 8'h03;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL wd_mul_ready got=%b want=0000", req_ready); end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        total++; if (rsp_id !== 2'd0 || rsp_data !== 8'h00) begin bad++; $display("FAIL wd_rsp got=%0d/%h want=0/00", rsp_id, rsp_data); end
        tick();
        for (int c = 0; c < 3; c++) begin
            total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || {mul_a, mul_b} !== 16'h0903) begin
                bad++; $display("FAIL wd_quiet[%0d] got=%b/%b/%h want=0/0/0903", c, rsp_valid, busy, {mul_a, mul_b});
            end
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_reset_mid_resp();
        test_fairness();
        test_backpressure();
        test_saturation();
        test_withdrawn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
